div_unit: RTL

Sequential 32-bit integer divider that covers the inverse of the ALU's MUL operation: signed/unsigned quotient and remainder (RISC-V DIV/DIVU/REM/REMU semantics). It runs beside the combinational ALU in the execute stage and is fed from the same register-file operands. Control and stall logic start it with a one-cycle pulse, hold the pipeline while `busy_o` is high, and capture `data_o` on `done_o`. It uses a fixed-latency radix-2 restoring algorithm: one quotient bit per clock.

---
 rtl/div_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Sequential radix-2 restoring divider (DIV/DIVU/REM/REMU) with a fixed
// 33-cycle latency from the start edge to the done pulse.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [0:0]       state;
  logic [1:0]       op;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] raw;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] result;

  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & data1_i[WIDTH-1];
    b_neg     = is_signed & data2_i[WIDTH-1];
    abs_a     = a_neg ? (~data1_i + 1'b1) : data1_i;
    abs_b     = b_neg ? (~data2_i + 1'b1) : data2_i;
  end

  // Dividend bits enter the remainder from the top of the quotient register,
  // which doubles as the shift register holding the not-yet-consumed bits.
  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    fits    = ~trial[WIDTH+1];
  end

  always_comb begin
    q_fin = neg_q ? (~quo + 1'b1) : quo;
    r_fin = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    if (div0) begin
      q_fin = '1;
      r_fin = raw;
    end
    result = op[1] ? r_fin : q_fin;
  end

  assign busy_o = (state == CALC);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      quo    <= '0;
      dvs    <= '0;
      raw    <= '0;
      rem    <= '0;
      cnt    <= '0;
      done_o <= 1'b0;
      data_o <= '0;
      Zero_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op    <= op_i;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            quo   <= abs_a;
            dvs   <= abs_b;
            raw   <= data1_i;
            div0  <= (data2_i == '0);
            rem   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt == LAST) begin
            data_o <= result;
            Zero_o <= (result == '0);
            done_o <= 1'b1;
            state  <= IDLE;
          end else begin
            rem <= fits ? trial[WIDTH:0] : shifted;
            quo <= {quo[WIDTH-2:0], fits};
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
